// File: rtl/ps2_host_tx_pkg.sv
// ps2_host_tx_pkg: shared definitions for the PS/2 host transmitter and receiver.
//   - state_t        : transmitter FSM encodings ST_IDLE..ST_WAITREL
//   - PS2_CMD_* / PS2_RESP_ACK : common command and response bytes
//   - LINE_CLK / LINE_DATA : index of each PS/2 line in the per-line sync arrays
//   - odd_parity()   : PS/2 frame parity bit for a data byte
package ps2_host_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INHIBIT,
    ST_RTS,
    ST_XFER,
    ST_ACK,
    ST_WAITREL
  } state_t;

  localparam logic [7:0] PS2_CMD_RESET    = 8'hFF;
  localparam logic [7:0] PS2_CMD_ENABLE   = 8'hF4;
  localparam logic [7:0] PS2_CMD_DEFAULTS = 8'hF6;
  localparam logic [7:0] PS2_RESP_ACK     = 8'hFA;

  localparam int NUM_LINES = 2;
  localparam int LINE_CLK  = 0;
  localparam int LINE_DATA = 1;

  // Bit that makes the 9-bit {parity, data} word contain an odd number of ones.
  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

endpackage

// File: rtl/ps2_host_tx_if.sv
// ps2_host_tx_if: command handshake and status between a client and ps2_host_tx.
//   tx_data  [7:0] byte to send (LSB first on the wire)
//   tx_valid       request; accepted when tx_valid & tx_ready
//   tx_ready       transmitter idle
//   busy           transfer in progress
//   done           one-cycle pulse, frame completed
//   error          one-cycle pulse, timeout or NACK
// modport master: client side; modport slave: transmitter side.
interface ps2_host_tx_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       busy;
  logic       done;
  logic       error;

  modport master (output tx_data, tx_valid, input tx_ready, busy, done, error);
  modport slave  (input tx_data, tx_valid, output tx_ready, busy, done, error);
endinterface

// File: rtl/ps2_line_sync.sv
// ps2_line_sync: 2-FF synchronizer plus one history FF for one PS/2 line.
//   clk, reset : system clock, asynchronous active-high reset
//   line_in    : raw asynchronous line
//   sync       : synchronized level
//   fall       : one-cycle pulse, 2 clk cycles after a falling line edge
// Flops reset to 1 (idle bus level) so reset release never fakes a fall.
module ps2_line_sync (
  input  logic clk,
  input  logic reset,
  input  logic line_in,
  output logic sync,
  output logic fall
);

  // [0],[1] synchronizer, [2] history of the synchronized level
  logic [2:0] sync_pipe;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) sync_pipe <= '1;
    else       sync_pipe <= {sync_pipe[1:0], line_in};
  end

  assign sync = sync_pipe[1];
  assign fall = sync_pipe[2] & ~sync_pipe[1];

endmodule

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: host-to-device PS/2 transmitter; sends one command byte.
//   clk, reset   : system clock, asynchronous active-high reset
//   bus (slave)  : tx_data/tx_valid/tx_ready handshake, busy/done/error status
//   ps2_clk_in   : raw PS/2 clock line      ps2_data_in : raw PS/2 data line
//   ps2_clk_oe   : 1 = pull clock low       ps2_data_oe : 1 = pull data low
//   rx_inhibit   : equals busy; tells the receiver to ignore our own line activity
// Optional feature macro PS2_TX_ACK_CHECK_EN: a NACK (data high at the ACK clock)
// ends the frame with an error pulse instead of done. Without it the ACK bit is
// ignored and a completed frame always pulses done.
module ps2_host_tx
  import ps2_host_tx_pkg::*;
#(
  parameter int INHIBIT_CYCLES = 2500,
  parameter int TIMEOUT_CYCLES = 375000,
  parameter int TO_W           = 19
) (
  input  logic           clk,
  input  logic           reset,
  ps2_host_tx_if.slave   bus,
  input  logic           ps2_clk_in,
  input  logic           ps2_data_in,
  output logic           ps2_clk_oe,
  output logic           ps2_data_oe,
  output logic           rx_inhibit
);

  localparam logic [TO_W-1:0] INH_LAST = TO_W'(INHIBIT_CYCLES - 1);
  localparam logic [TO_W-1:0] TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);

  // ---- line synchronizers ----
  logic [NUM_LINES-1:0] line_in, line_sync, line_fall;
  assign line_in = {ps2_data_in, ps2_clk_in};

  for (genvar g = 0; g < NUM_LINES; g++) begin : g_sync
    ps2_line_sync u_sync (
      .clk     (clk),
      .reset   (reset),
      .line_in (line_in[g]),
      .sync    (line_sync[g]),
      .fall    (line_fall[g])
    );
  end

  logic clk_sync, data_sync, clk_fall, unused_data_fall;
  assign clk_sync         = line_sync[LINE_CLK];
  assign data_sync        = line_sync[LINE_DATA];
  assign clk_fall         = line_fall[LINE_CLK];
  assign unused_data_fall = line_fall[LINE_DATA];

  // ---- FSM ----
  state_t          state;
  logic [8:0]      shreg;     // {parity, data}, shifted out LSB first
  logic [TO_W-1:0] cnt;       // inhibit timer, then inter-fall watchdog
  logic [3:0]      bitcnt;
  logic            tx_ready_q, busy_q, done_q, error_q;
`ifdef PS2_TX_ACK_CHECK_EN
  logic            nack;
`endif

  // Watchdog covers every state where we wait on the device.
  logic wd_active, wd_expired;
  assign wd_active  = (state == ST_RTS) || (state == ST_XFER) ||
                      (state == ST_ACK) || (state == ST_WAITREL);
  assign wd_expired = wd_active && (cnt == TO_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      shreg       <= '0;
      cnt         <= '0;
      bitcnt      <= '0;
      tx_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      ps2_clk_oe  <= 1'b0;
      ps2_data_oe <= 1'b0;
`ifdef PS2_TX_ACK_CHECK_EN
      nack        <= 1'b0;
`endif
    end else begin
      done_q  <= 1'b0;
      error_q <= 1'b0;
      if (wd_expired) begin
        // Device stopped clocking: let go of the bus and report.
        state       <= ST_IDLE;
        cnt         <= '0;
        ps2_clk_oe  <= 1'b0;
        ps2_data_oe <= 1'b0;
        busy_q      <= 1'b0;
        tx_ready_q  <= 1'b1;
        error_q     <= 1'b1;
      end else begin
        if (wd_active) cnt <= clk_fall ? '0 : cnt + 1'b1;
        case (state)
          ST_IDLE: begin
            if (bus.tx_valid) begin
              shreg      <= {odd_parity(bus.tx_data), bus.tx_data};
              cnt        <= '0;
              state      <= ST_INHIBIT;
              tx_ready_q <= 1'b0;
              busy_q     <= 1'b1;
              ps2_clk_oe <= 1'b1;
            end
          end
          ST_INHIBIT: begin
            // Clock falls here are our own pull-down; nothing to react to.
            if (cnt == INH_LAST) begin
              ps2_data_oe <= 1'b1;  // start bit
              cnt         <= '0;
              state       <= ST_RTS;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          ST_RTS: begin
            ps2_clk_oe <= 1'b0;     // hand the clock to the device
            bitcnt     <= '0;
            cnt        <= '0;
            state      <= ST_XFER;
          end
          ST_XFER: begin
            // Change data while the device holds clock low; it samples on the rise.
            if (clk_fall) begin
              if (bitcnt == 4'd9) begin
                ps2_data_oe <= 1'b0;  // stop bit: released line reads 1
                state       <= ST_ACK;
              end else begin
                ps2_data_oe <= ~shreg[0];
                shreg       <= {1'b0, shreg[8:1]};
                bitcnt      <= bitcnt + 1'b1;
              end
            end
          end
          ST_ACK: begin
            if (clk_fall) begin
`ifdef PS2_TX_ACK_CHECK_EN
              nack <= data_sync;
`endif
              cnt   <= '0;
              state <= ST_WAITREL;
            end
          end
          ST_WAITREL: begin
            if (clk_sync && data_sync) begin
              state      <= ST_IDLE;
              cnt        <= '0;
              busy_q     <= 1'b0;
              tx_ready_q <= 1'b1;
`ifdef PS2_TX_ACK_CHECK_EN
              done_q     <= ~nack;
              error_q    <= nack;
`else
              done_q     <= 1'b1;
`endif
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  assign bus.tx_ready = tx_ready_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.error    = error_q;
  assign rx_inhibit   = busy_q;

endmodule
